// File: rtl/rtc_defs_pkg.sv
// Shared definitions for the RTC write path: default register addresses,
// scheduler FSM encoding and a constant-width helper.
package rtc_defs;

  localparam logic [7:0] RTC_ADDR_SEC      = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN      = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR     = 8'h23;
  localparam logic [7:0] RTC_ADDR_DAY      = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH    = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR     = 8'h26;
  localparam logic [7:0] RTC_ADDR_CHR_SEC  = 8'h41;
  localparam logic [7:0] RTC_ADDR_CHR_MIN  = 8'h42;
  localparam logic [7:0] RTC_ADDR_CHR_HOUR = 8'h43;

  // Field 0 sits in the least significant slice.
  localparam logic [71:0] RTC_DEFAULT_MAP = {
    RTC_ADDR_CHR_SEC, RTC_ADDR_CHR_MIN, RTC_ADDR_CHR_HOUR,
    RTC_ADDR_YEAR,    RTC_ADDR_MONTH,   RTC_ADDR_DAY,
    RTC_ADDR_SEC,     RTC_ADDR_MIN,     RTC_ADDR_HOUR
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rtc_prio_pick.sv
// Rotating priority encoder: grants the first set request at or above start,
// wrapping past the top index.
module rtc_prio_pick
  import rtc_defs::*;
#(
  parameter int N     = 9,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(start) + off) % N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rtc_write_scheduler.sv
// Buffers per-field RTC writes in a pending bitmap with data shadows and
// issues them one at a time over a req/ack bus with optional timeout.
module rtc_write_scheduler
  import rtc_defs::*;
#(
  parameter int                          NUM_FIELDS = 9,
  parameter int                          ADDR_W     = 8,
  parameter int                          DATA_W     = 8,
  parameter logic [NUM_FIELDS*ADDR_W-1:0] ADDR_TABLE = RTC_DEFAULT_MAP,
  parameter int                          RR_MODE    = 0,
  parameter int                          TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_FIELDS-1:0]          field_req,
  input  logic [NUM_FIELDS*DATA_W-1:0]   field_data,
  input  logic                           flush,
  output logic                           bus_req,
  output logic [ADDR_W-1:0]              bus_addr,
  output logic [DATA_W-1:0]              bus_data,
  input  logic                           bus_ack,
  output logic [NUM_FIELDS-1:0]          pending,
  output logic                           busy,
  output logic                           done,
  output logic [clog2(NUM_FIELDS)-1:0]   done_idx,
  output logic                           err
);

  localparam int IDX_W = clog2(NUM_FIELDS);
  localparam int CNT_W = clog2(TIMEOUT + 1);

  state_t                  state, state_next;
  logic [NUM_FIELDS-1:0]   pending_next;
  logic [DATA_W-1:0]       shadow [NUM_FIELDS];
  logic [IDX_W-1:0]        cur_idx, ptr, pick_start, pick_idx;
  logic                    pick_valid;
  logic [DATA_W-1:0]       sel_data;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    ack_hit, tmo_hit, select;

  assign pick_start = (RR_MODE != 0) ? ptr : '0;

  rtc_prio_pick #(.N(NUM_FIELDS), .IDX_W(IDX_W)) u_pick (
    .req   (pending),
    .start (pick_start),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  assign select  = (state == ST_IDLE) && pick_valid;
  assign ack_hit = (state == ST_ISSUE) && bus_ack;
  assign tmo_hit = (TIMEOUT != 0) && (state == ST_ISSUE) && !bus_ack &&
                   (tmo_cnt == CNT_W'(TIMEOUT - 1));

  assign bus_req = (state == ST_ISSUE);
  assign busy    = (|pending) || (state != ST_IDLE);

  // A request landing on the selection edge is forwarded so the newest value is written.
  assign sel_data = field_req[pick_idx] ? field_data[pick_idx*DATA_W +: DATA_W]
                                        : shadow[pick_idx];

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (pick_valid) state_next = ST_ISSUE;
      ST_ISSUE: if (ack_hit) state_next = ST_IDLE;
                else if (tmo_hit) state_next = ST_ABORT;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // New requests are applied last so they beat both flush and the ack clear.
  always_comb begin
    pending_next = pending;
    if (flush) pending_next = '0;
    if (ack_hit) pending_next[cur_idx] = 1'b0;
    pending_next = pending_next | field_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pending  <= '0;
      bus_addr <= '0;
      bus_data <= '0;
      cur_idx  <= '0;
      ptr      <= '0;
      tmo_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      done_idx <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      done    <= ack_hit;
      err     <= tmo_hit;
      if (select) begin
        cur_idx  <= pick_idx;
        bus_addr <= ADDR_TABLE[pick_idx*ADDR_W +: ADDR_W];
        bus_data <= sel_data;
        tmo_cnt  <= '0;
      end else if (state == ST_ISSUE && !bus_ack) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (ack_hit || tmo_hit) begin
        done_idx <= cur_idx;
        ptr      <= (cur_idx == IDX_W'(NUM_FIELDS - 1)) ? '0 : cur_idx + IDX_W'(1);
      end
    end
  end

  // NOTE: the shadow array is small and its reset value is architecturally
  // visible, so it is reset; larger storage arrays normally are not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_FIELDS; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FIELDS; i++)
        if (field_req[i]) shadow[i] <= field_data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_rtc_write_scheduler.sv
// Directed bench: fixed-priority instance with a short timeout and a
// round-robin instance without timeout, sharing clock and reset.
module tb_rtc_write_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [8:0]  req_a = '0, req_b = '0;
  logic [71:0] data_a = '0, data_b = '0;
  logic        flush_a = 1'b0, flush_b = 1'b0;
  logic        ack_a = 1'b0, ack_b = 1'b0;

  logic        bus_req_a, bus_req_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [7:0]  addr_a, addr_b, bdata_a, bdata_b;
  logic [8:0]  pending_a, pending_b;
  logic [3:0]  idx_a, idx_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_write_scheduler #(.RR_MODE(0), .TIMEOUT(4)) u_fix (
    .clk(clk), .reset_n(reset_n), .field_req(req_a), .field_data(data_a),
    .flush(flush_a), .bus_req(bus_req_a), .bus_addr(addr_a), .bus_data(bdata_a),
    .bus_ack(ack_a), .pending(pending_a), .busy(busy_a), .done(done_a),
    .done_idx(idx_a), .err(err_a)
  );

  rtc_write_scheduler #(.RR_MODE(1), .TIMEOUT(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .field_req(req_b), .field_data(data_b),
    .flush(flush_b), .bus_req(bus_req_b), .bus_addr(addr_b), .bus_data(bdata_b),
    .bus_ack(ack_b), .pending(pending_b), .busy(busy_b), .done(done_b),
    .done_idx(idx_b), .err(err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bus_a(input string tag);
    int n;
    n = 0;
    while (bus_req_a !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(bus_req_a), 1);
  endtask

  task automatic serve_a(input string tag, input logic [7:0] exp_addr,
                         input logic [7:0] exp_data, input logic [3:0] exp_idx,
                         input logic [8:0] exp_pend);
    wait_bus_a(tag);
    check({tag, "_addr"}, 32'(addr_a), 32'(exp_addr));
    check({tag, "_data"}, 32'(bdata_a), 32'(exp_data));
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check({tag, "_done"}, 32'(done_a), 1);
    check({tag, "_idx"}, 32'(idx_a), 32'(exp_idx));
    check({tag, "_req_low"}, 32'(bus_req_a), 0);
    check({tag, "_pend"}, 32'(pending_a), 32'(exp_pend));
    check({tag, "_busy"}, 32'(busy_a), 32'(exp_pend != 0));
  endtask

  task automatic serve_b(input string tag, input logic [7:0] exp_addr,
                         input logic [7:0] exp_data, input logic [3:0] exp_idx,
                         input bit rereq, input logic [8:0] exp_pend);
    int n;
    n = 0;
    while (bus_req_b !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(bus_req_b), 1);
    check({tag, "_addr"}, 32'(addr_b), 32'(exp_addr));
    check({tag, "_data"}, 32'(bdata_b), 32'(exp_data));
    ack_b = 1'b1;
    if (rereq) req_b[exp_idx] = 1'b1;
    step();
    ack_b = 1'b0;
    req_b = '0;
    check({tag, "_done"}, 32'(done_b), 1);
    check({tag, "_idx"}, 32'(idx_b), 32'(exp_idx));
    check({tag, "_pend"}, 32'(pending_b), 32'(exp_pend));
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_bus_req", 32'(bus_req_a), 0);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_data", 32'(bdata_a), 0);
    check("rst_pending", 32'(pending_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_idx", 32'(idx_a), 0);
    reset_n = 1'b1;
    step();

    // Single request with latency checks
    data_a[0*8 +: 8] = 8'h15;
    req_a = 9'h001;
    step();
    req_a = '0;
    check("t1_pend", 32'(pending_a), 1);
    check("t1_req_early", 32'(bus_req_a), 0);
    check("t1_busy", 32'(busy_a), 1);
    step();
    check("t1_req", 32'(bus_req_a), 1);
    check("t1_addr", 32'(addr_a), 32'h23);
    check("t1_data", 32'(bdata_a), 32'h15);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check("t1_done", 32'(done_a), 1);
    check("t1_idx", 32'(idx_a), 0);
    check("t1_pend_clr", 32'(pending_a), 0);
    check("t1_busy_clr", 32'(busy_a), 0);
    step();
    check("t1_done_pulse", 32'(done_a), 0);

    // Simultaneous fields 2, 5, 8 in fixed priority
    data_a[2*8 +: 8] = 8'hA2;
    data_a[5*8 +: 8] = 8'hA5;
    data_a[8*8 +: 8] = 8'hA8;
    req_a = 9'h124;
    step();
    req_a = '0;
    check("t2_pend", 32'(pending_a), 32'h124);
    serve_a("t2_f2", 8'h21, 8'hA2, 4'd2, 9'h120);
    serve_a("t2_f5", 8'h26, 8'hA5, 4'd5, 9'h100);
    serve_a("t2_f8", 8'h41, 8'hA8, 4'd8, 9'h000);

    // Coalescing, then an update on the ack cycle forces a second write
    data_a[1*8 +: 8] = 8'h10;
    req_a = 9'h002;
    step();
    data_a[1*8 +: 8] = 8'h20;
    step();
    req_a = '0;
    check("t4_req", 32'(bus_req_a), 1);
    check("t4_addr", 32'(addr_a), 32'h22);
    check("t4_data", 32'(bdata_a), 32'h20);
    data_a[1*8 +: 8] = 8'h30;
    req_a = 9'h002;
    ack_a = 1'b1;
    step();
    req_a = '0;
    ack_a = 1'b0;
    check("t4_done", 32'(done_a), 1);
    check("t4_idx", 32'(idx_a), 1);
    check("t4_pend_kept", 32'(pending_a), 32'h002);
    serve_a("t4_rewrite", 8'h22, 8'h30, 4'd1, 9'h000);

    // Timeout after four ISSUE cycles, then a successful retry
    data_a[4*8 +: 8] = 8'h07;
    req_a = 9'h010;
    step();
    req_a = '0;
    step();
    check("t5_req_c0", 32'(bus_req_a), 1);
    check("t5_addr", 32'(addr_a), 32'h25);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("t5_req_c%0d", i), 32'(bus_req_a), 1);
    end
    step();
    check("t5_req_drop", 32'(bus_req_a), 0);
    check("t5_err", 32'(err_a), 1);
    check("t5_done_low", 32'(done_a), 0);
    check("t5_idx", 32'(idx_a), 4);
    check("t5_pend_kept", 32'(pending_a), 32'h010);
    step();
    check("t5_err_pulse", 32'(err_a), 0);
    serve_a("t5_retry", 8'h25, 8'h07, 4'd4, 9'h000);

    // Flush together with a new request on field 3 while field 5 is selected
    data_a[5*8 +: 8] = 8'h55;
    data_a[6*8 +: 8] = 8'h66;
    data_a[3*8 +: 8] = 8'h33;
    req_a = 9'h060;
    step();
    req_a = 9'h008;
    flush_a = 1'b1;
    step();
    req_a = '0;
    flush_a = 1'b0;
    check("t6_flush_pend", 32'(pending_a), 32'h008);
    serve_a("t6_inflight", 8'h26, 8'h55, 4'd5, 9'h008);
    serve_a("t6_f3", 8'h24, 8'h33, 4'd3, 9'h000);

    // Round-robin alternation on fields 0 and 1
    data_b[0*8 +: 8] = 8'h0A;
    data_b[1*8 +: 8] = 8'h0B;
    req_b = 9'h003;
    step();
    req_b = '0;
    check("rr_pend", 32'(pending_b), 32'h003);
    serve_b("rr_g0", 8'h23, 8'h0A, 4'd0, 1'b1, 9'h003);
    serve_b("rr_g1", 8'h22, 8'h0B, 4'd1, 1'b1, 9'h003);
    serve_b("rr_g2", 8'h23, 8'h0A, 4'd0, 1'b1, 9'h003);
    serve_b("rr_g3", 8'h22, 8'h0B, 4'd1, 1'b1, 9'h003);
    serve_b("rr_g4", 8'h23, 8'h0A, 4'd0, 1'b0, 9'h002);
    serve_b("rr_g5", 8'h22, 8'h0B, 4'd1, 1'b0, 9'h000);

    // Asynchronous reset in the middle of an ISSUE
    data_a[0*8 +: 8] = 8'h5A;
    req_a = 9'h041;
    step();
    req_a = '0;
    step();
    check("t7_req", 32'(bus_req_a), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_req_async", 32'(bus_req_a), 0);
    check("t7_pend", 32'(pending_a), 0);
    check("t7_busy", 32'(busy_a), 0);
    check("t7_addr", 32'(addr_a), 0);
    check("t7_data", 32'(bdata_a), 0);
    check("t7_idx", 32'(idx_a), 0);
    check("t7_done", 32'(done_a), 0);
    step();
    reset_n = 1'b1;
    step();
    step();
    check("t7_post_req", 32'(bus_req_a), 0);
    check("t7_post_pend", 32'(pending_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_write_scheduler.md
# rtc_write_scheduler

Parametrised write scheduler for the RTC parallel bus. It accepts independent per-field write requests (time, date, chronometer, or any register set), each carrying a data value. It queues them as a pending bitmap and issues them one at a time as address/data transactions with a req/ack handshake toward the RTC bus controller. It replaces single-cycle address selection with buffered, arbitrated, acknowledged writes, and sits between the edit-counter logic and the RTC bus interface.

## Interface
- NUM_FIELDS, 9, number of writable fields; index 0 has highest fixed priority
- ADDR_W, 8, RTC register address width
- DATA_W, 8, write data width
- ADDR_TABLE, {8'h41,8'h42,8'h43,8'h26,8'h25,8'h24,8'h21,8'h22,8'h23}, packed NUM_FIELDS*ADDR_W map; field i uses slice i (0=hour 0x23, 1=min 0x22, 2=sec 0x21, 3=day 0x24, 4=month 0x25, 5=year 0x26, 6..8=chrono hour/min/sec 0x43/0x42/0x41)
- RR_MODE, 0, 0 = fixed priority, 1 = round-robin
- TIMEOUT, 255, ISSUE cycles before abort; 0 disables timeout

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- field_req  in  NUM_FIELDS  one-cycle request pulses, several may be high at once
- field_data  in  NUM_FIELDS*DATA_W  data for field i in slice i, sampled when field_req[i]=1
- flush  in  1  synchronous clear of all pending requests
- bus_req  out  1  transaction valid
- bus_addr  out  ADDR_W  RTC register address, stable while bus_req=1
- bus_data  out  DATA_W  write data, stable while bus_req=1
- bus_ack  in  1  controller accepted the transaction
- pending  out  NUM_FIELDS  outstanding request bitmap
- busy  out  1  high when pending≠0 or the FSM is not IDLE
- done  out  1  one-cycle pulse on completed write
- done_idx  out  clog2(NUM_FIELDS)  field index of the last done or err
- err  out  1  one-cycle pulse on timeout abort

## Operation
- Per field: pending bit plus DATA_W shadow register. field_req[i] sets pending[i] and loads shadow[i]. A repeat request before service overwrites the data (coalescing, single write).
- FSM states:
  - IDLE: if pending≠0, pick index g, load bus_addr=ADDR_TABLE[g] and bus_data=shadow[g], go to ISSUE.
  - ISSUE: bus_req=1. On bus_ack=1: clear pending[g], pulse done, set done_idx=g, go to IDLE.
  - ABORT (timeout): pulse err, set done_idx=g, keep pending[g], go to IDLE.
- Selection:
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set index at or above ptr, wrapping. ptr = g+1 mod NUM_FIELDS after done or err.
- Data is snapshotted at selection. A new field_req[g] during ISSUE updates shadow[g] and re-sets pending[g] even on the ack cycle, so the field is written again with the new value. The set takes precedence over the clear.
- flush clears all pending bits. An in-flight ISSUE completes normally. flush and field_req in the same cycle: the request wins for that field.
- Timeout counter resets on entry to ISSUE and increments each ISSUE cycle without ack. When it reaches TIMEOUT, the FSM drops bus_req and goes to ABORT.

## Timing
- Reset values: state=IDLE, pending=0, shadows=0, bus_req=0, bus_addr=0, bus_data=0, done=0, err=0, done_idx=0, ptr=0, busy=0.
- field_req at edge t → pending visible at t+1. With the FSM idle, bus_req rises at t+2.
- Minimum service is 2 cycles per write: IDLE select, then ISSUE with same-cycle ack. Back-to-back writes therefore have bus_req low for at least one cycle between them.
- bus_req, bus_addr and bus_data must not change while bus_req=1 and bus_ack=0.
- done and err are registered and assert in the cycle after the ack or timeout edge.
- reset_n low mid-transaction drops bus_req immediately (asynchronous) and discards all pending writes.

## Structure
- Shared package rtc_defs: default RTC address constants (hour/min/sec, day/month/year, chrono), FSM state encoding, clog2 helper.
- One sub-module, rtc_prio_pick: combinational rotating priority encoder. Inputs are the request vector and start pointer; outputs are the grant index and valid. Used with start pointer 0 in fixed mode.

## Test plan
- Single request, defaults: field_req[0] with data 0x15 → bus_req with addr 0x23, data 0x15; ack → done, done_idx=0, pending=0.
- Simultaneous fields 2, 5 and 8, RR_MODE=0, immediate ack → writes in order 0x21, 0x26, 0x41; three done pulses; busy falls after the last one.
- RR_MODE=1, requests on 0 and 1 kept re-asserted after every done → grants alternate 0, 1, 0, 1.
- Coalescing and in-flight update: two requests on field 1 (0x10 then 0x20) before service → one write of 0x20. A third request (0x30) during ISSUE → a second write of 0x30 follows.
- TIMEOUT=4, bus_ack held low → bus_req high for 4 cycles, then err with done_idx=g, pending retained; a later ack completes the retry.
- reset_n pulsed low during ISSUE → bus_req=0 asynchronously and all outputs return to reset values; flush with field_req[3] in the same cycle → only pending[3] remains.
